uart_rx: RTL
============

Name: uart_rx

Overview:
Serial UART receiver that decodes the 8N1 stream the SoC drives on its `io_uart_txd` line into bytes. It is the receive end of the SoC UART transmit path. It is used in the host-side harness, and is also reusable as the SoC RX front end. Bytes are buffered in a small FIFO and delivered over a valid/ready interface, with framing and overrun error reporting.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200 baud); must be ≥ 4.
- FIFO_DEPTH, 4, received-byte buffer entries; power of two, ≥ 2.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  asynchronous, active-low reset.
- rxd  in  1  serial input, idle high, asynchronous to clock.
- data  out  8  head-of-FIFO byte; valid only while data_valid=1.
- data_valid  out  1  FIFO non-empty.
- data_ready  in  1  consumer accepts data when data_valid & data_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: good byte dropped because FIFO full.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async): synchronizer flops to 1, state IDLE, counters 0, FIFO empty; data=0, data_valid=0, frame_err=0, overrun=0, busy=0.
- rxd passes through a 2-flop synchronizer (rxd_s); all decisions use rxd_s, adding 2 cycles of latency.
- Bit counter cnt counts 0..CLKS_PER_BIT-1; bit index idx counts 0..7.
- IDLE: rxd_s==0 -> START, cnt=0.
- START: at cnt==CLKS_PER_BIT/2-1 (integer division), resample.
  - rxd_s==0 -> DATA, cnt=0, idx=0.
  - rxd_s==1 -> glitch; return to IDLE with no error.
- DATA: at cnt==CLKS_PER_BIT-1, shift rxd_s into bit idx, LSB first.
  - After idx==7 -> STOP, cnt=0.
  - Samples therefore land at bit centres.
- STOP: at cnt==CLKS_PER_BIT-1, sample rxd_s.
  - rxd_s==1 -> push byte and go to IDLE immediately (no wait for end of stop bit).
  - rxd_s==0 -> frame_err pulse, byte discarded, go to BREAK.
- BREAK: stay until rxd_s==1, then IDLE. A held-low line yields exactly one frame_err.
- Push occurs the cycle after the stop sample; data_valid rises in that same cycle when the FIFO was empty.
- FIFO rules:
  - Pop = data_valid & data_ready.
  - Pop is evaluated before push in the same cycle, so a full FIFO with a simultaneous pop accepts the push.
  - Full with no pop -> byte dropped, overrun pulses in the push cycle, contents unchanged.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter width is $clog2(FIFO_DEPTH)+1.
  - data presents the head entry registered; it must not change while data_valid=1 and data_ready=0.
- frame_err and overrun never assert in the same cycle, because a byte with a framing error is never pushed.
- Async reset mid-frame aborts the frame. No partial byte is ever pushed, and after release the block waits for a new falling edge.

Decomposition:
- Shared package uart_pkg holds:
  - rx_state_t enum: IDLE, START, DATA, STOP, BREAK.
  - UART_DATA_BITS=8.
  - UART_DEFAULT_CLKS_PER_BIT=434, shared with the matching transmitter.
- One sub-module, uart_rx_fifo (DEPTH, WIDTH): synchronous FIFO with push/pop/full/empty and registered head output.
- The FSM, counters and synchronizer live in uart_rx.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Single frame 0xA5 with stop=1 -> data_valid rises 1 cycle after the stop sample, data=0xA5; with data_ready held 1 it pops next cycle and data_valid returns to 0.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap and data_ready=1 -> three bytes delivered in order, no errors.
- rxd low for 5 cycles, then high -> glitch rejected; no push, no frame_err, busy back to 0 within 10 cycles.
- Frame 0x3C with stop=0, line held low for 100 cycles -> frame_err exactly one pulse, nothing pushed; a following good 0x81 is received correctly.
- data_ready=0, send 5 frames 0x01..0x05 -> first four buffered, overrun pulses once on 0x05; draining yields 0x01..0x04.
- FIFO full and data_ready asserted exactly in the 6th frame's push cycle -> push accepted, no overrun.
- Assert reset during DATA bit 3 of a frame, release, send 0x7E -> only 0x7E delivered; all outputs 0 during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// default baud divider used by both the receiver and the matching transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes. The head entry is held in its own
// register, so the consumer sees a flop output that only moves on a pop or first push.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_pop;
    logic             w_write;
    logic [CW-1:0]    w_remaining;
    logic [AW-1:0]    w_rd_next;

    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == CW'(DEPTH));
    assign o_head      = r_head;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign w_pop       = i_pop & ~o_empty;
    assign w_write     = i_push & (~o_full | w_pop);
    assign w_remaining = r_count - CW'(w_pop);
    assign w_rd_next   = r_rd_ptr + AW'(1);

    // NOTE: the storage array has no reset; occupancy and pointers alone define
    // which entries are meaningful, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            r_count <= r_count + CW'(w_write) - CW'(w_pop);

            // Head bypass: an empty (or emptying) FIFO takes the incoming byte directly.
            if (w_remaining == '0) begin
                if (w_write) begin
                    r_head <= i_push_data;
                end
            end else if (w_pop) begin
                r_head <= r_mem[w_rd_next];
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, bit-timing FSM sampling at
// bit centres, and a byte FIFO with valid/ready delivery plus error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

    logic                      r_rxd_meta;
    logic                      r_rxd_s;
    rx_state_t                 r_state;
    logic [CW-1:0]             r_cnt;
    logic [IW-1:0]             r_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_frame_err;
    logic                      r_overrun;

    logic                      w_bit_end;
    logic                      w_half_bit;
    logic                      w_stop_sample;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_fifo_empty;
    logic                      w_fifo_full;

    assign w_bit_end     = (r_cnt == CNT_LAST);
    assign w_half_bit    = (r_cnt == CNT_HALF);
    assign w_stop_sample = (r_state == STOP) && w_bit_end;
    assign w_push        = w_stop_sample & r_rxd_s;
    assign w_pop         = data_valid & data_ready;

    // The synchronizer resets to the idle level so release never looks like a start bit.
    // NOTE: every sequential block uses non-blocking assignments so that all
    // flops sample the pre-edge values, independent of block ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!r_rxd_s) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_half_bit) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= r_rxd_s ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_shift[r_idx] <= r_rxd_s;
                        r_cnt          <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_state <= STOP;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= r_rxd_s ? IDLE : BREAK;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                // A line held low stays here, so it reports one framing error, not many.
                BREAK: begin
                    r_cnt <= '0;
                    if (r_rxd_s) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_sample & ~r_rxd_s;
            r_overrun   <= w_push & w_fifo_full & ~w_pop;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (r_shift),
        .i_pop       (w_pop),
        .o_head      (data),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    assign data_valid = ~w_fifo_empty;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);

endmodule
